gate_tt_sequencer: RTL
======================

// Module: gate_tt_sequencer
// PURPOSE
//  Self-checking truth-table engine for the basic-logic-gate library. Drives every input
//  combination into a gate under test, waits a settle window, samples the gate output and
//  compares it against a reference op. Sits directly upstream of the gate (drives its inputs)
//  and consumes its output. Replaces hand-written #delay stimulus with a clocked, repeatable sweep.
// PARAMETERS
//  N_IN    2  gate input count; sweep covers 2**N_IN vectors (1..8)
//  SETTLE  2  cycles each vector is held before the output is sampled (>=1; elaboration error if 0)
//  ERR_W   8  width of the mismatch counter
// PORTS
//  clk         in   1      single clock; all state on posedge
//  rst         in   1      synchronous, active-high reset
//  start       in   1      begin a sweep; accepted only in IDLE or DONE
//  op_sel      in   3      reference op: 0 AND,1 OR,2 NAND,3 NOR,4 XOR,5 XNOR,6 NOT(bit0),7 BUF(bit0)
//  stim_vec    out  N_IN   drives gate inputs; stim_vec[N_IN-1] = input a, stim_vec[0] = last input
//  y_in        in   1      gate output under test
//  busy        out  1      high from the start acceptance through the final CHECK
//  done        out  1      high in DONE; held until the next accepted start or rst
//  pass        out  1      valid while done: 1 iff err_count == 0
//  err_count   out  ERR_W  mismatches this sweep; saturates at all-ones
//  fail_valid  out  1      set on the first mismatch of a sweep; sticky until the next start
//  fail_vec    out  N_IN   stim_vec of the first mismatch; holds its value after later mismatches
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0: stim_vec, busy, done, pass, err_count, fail_valid, fail_vec.
//  - FSM IDLE -> SETTLE -> CHECK -> (SETTLE | DONE); DONE -> SETTLE on start.
//  - Start edge: op_sel is latched. vec=0, settle cnt=0, err_count/fail_valid/fail_vec are cleared,
//    done=0, busy=1. op_sel changes during a sweep are ignored.
//  - SETTLE: stim_vec=vec, held stable. cnt increments each cycle. When cnt==SETTLE-1 -> CHECK.
//  - CHECK: one cycle; stim_vec is still vec. Compare y_in against ref(op, vec).
//    On mismatch: err_count+1 (saturating). If fail_valid==0, capture fail_vec=vec and set fail_valid=1.
//  - After CHECK: if vec is all-ones -> DONE (busy=0, done=1). Otherwise vec+1, cnt=0 -> SETTLE.
//  - Timing: each vector occupies SETTLE+1 cycles. done rises 2**N_IN*(SETTLE+1) edges after the
//    start edge. Example: N_IN=2, SETTLE=2 gives 12.
//  - DONE: stim_vec holds the last vector (all-ones). Results are frozen until start or rst.
//  - start while busy: ignored, no effect on sweep.
//  - start in the same cycle as rst: rst wins; state goes to IDLE.
//  - rst mid-sweep: next cycle is the reset state; a partial sweep reports nothing.
//  - Reduction ops apply over all N_IN bits. NOT/BUF use bit 0 only; the other bits still sweep.
//  - y_in is treated as settled; it is sampled only in CHECK and is not synchronised.
// STRUCTURE
//  - gate_pkg: op_sel encodings (OP_AND..OP_BUF) and state encodings (S_IDLE, S_SETTLE, S_CHECK, S_DONE).
//  - Sub-module gate_ref_model: combinational (op, vec) -> expected bit, parameterised by N_IN.
//    The bench reuses it.
//  - Top: FSM, vector counter, settle counter, error/capture registers.
// TESTING  (DUT = andgate, a=stim_vec[1], b=stim_vec[0]; N_IN=2, SETTLE=2 unless stated)
//  1 rst, start with op=AND -> stim_vec 00,01,10,11, each for 3 cycles; done after 12 cycles;
//    pass=1, err_count=0, fail_valid=0.
//  2 start, op=OR -> err_count=2, fail_valid=1, fail_vec=01, pass=0.
//  3 start, op=NAND, ERR_W=1 -> 4 mismatches; err_count saturates at 1; fail_vec=00.
//  4 start pulsed again at cycles 3 and 7 of a sweep -> ignored; done still at cycle 12; results as in 1.
//  5 rst asserted at cycle 6 of a sweep -> next cycle all outputs 0, state IDLE; a fresh start
//    completes as in 1.
//  6 DONE with err_count=2 (after 2), then start with op=AND -> counters clear on the start edge;
//    final pass=1; op_sel toggled mid-sweep has no effect.

Source files
------------

// File: rtl/gate_tt_sequencer_pkg.sv
// Shared encodings for the gate truth-table sequencer: reference ops and FSM states.
package gate_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_BUF  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/gate_tt_sequencer_ref.sv
// Combinational reference op: the bit a correct gate should produce for a given input vector.
module gate_ref_model
    import gate_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  op_e             op,
    input  logic [N_IN-1:0] vec,
    output logic            expected
);

    // Reductions span the full vector; NOT/BUF look only at the last input.
    always_comb begin
        expected = 1'b0;
        case (op)
            OP_AND:  expected = &vec;
            OP_OR:   expected = |vec;
            OP_NAND: expected = ~&vec;
            OP_NOR:  expected = ~|vec;
            OP_XOR:  expected = ^vec;
            OP_XNOR: expected = ~^vec;
            OP_NOT:  expected = ~vec[0];
            OP_BUF:  expected = vec[0];
            default: expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_tt_sequencer.sv
// Sweeps every input combination into a gate, holds each for SETTLE cycles, then checks
// the gate output against the latched reference op and records mismatches.
module gate_tt_sequencer
    import gate_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op_sel,
    output logic [N_IN-1:0]  stim_vec,
    input  logic             y_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [N_IN-1:0]  fail_vec
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    generate
        if (SETTLE < 1) begin : g_bad_settle
            $error("gate_tt_sequencer: SETTLE must be at least 1");
        end
        if (N_IN < 1 || N_IN > 8) begin : g_bad_n_in
            $error("gate_tt_sequencer: N_IN must be in 1..8");
        end
    endgenerate

    state_e            state_reg, state_next;
    op_e               op_reg, op_next;
    logic [N_IN-1:0]   vec_reg, vec_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [ERR_W-1:0]  err_reg, err_next;
    logic              fail_valid_reg, fail_valid_next;
    logic [N_IN-1:0]   fail_vec_reg, fail_vec_next;
    logic              ref_bit;

    gate_ref_model #(.N_IN(N_IN)) u_ref (
        .op       (op_reg),
        .vec      (vec_reg),
        .expected (ref_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            op_reg         <= OP_AND;
            vec_reg        <= '0;
            cnt_reg        <= '0;
            err_reg        <= '0;
            fail_valid_reg <= 1'b0;
            fail_vec_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            op_reg         <= op_next;
            vec_reg        <= vec_next;
            cnt_reg        <= cnt_next;
            err_reg        <= err_next;
            fail_valid_reg <= fail_valid_next;
            fail_vec_reg   <= fail_vec_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        op_next         = op_reg;
        vec_next        = vec_reg;
        cnt_next        = cnt_reg;
        err_next        = err_reg;
        fail_valid_next = fail_valid_reg;
        fail_vec_next   = fail_vec_reg;

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next      = S_SETTLE;
                    op_next         = op_e'(op_sel);
                    vec_next        = '0;
                    cnt_next        = '0;
                    err_next        = '0;
                    fail_valid_next = 1'b0;
                    fail_vec_next   = '0;
                end
            end
            S_SETTLE: begin
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == CW'(SETTLE - 1)) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (y_in != ref_bit) begin
                    if (err_reg != '1) begin
                        err_next = err_reg + ERR_W'(1);
                    end
                    // Only the first failing vector of a sweep is kept for debug.
                    if (!fail_valid_reg) begin
                        fail_valid_next = 1'b1;
                        fail_vec_next   = vec_reg;
                    end
                end
                if (&vec_reg) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_SETTLE;
                    vec_next   = vec_reg + N_IN'(1);
                    cnt_next   = '0;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign stim_vec   = vec_reg;
    assign busy       = (state_reg == S_SETTLE) || (state_reg == S_CHECK);
    assign done       = (state_reg == S_DONE);
    assign pass       = done && (err_reg == '0);
    assign err_count  = err_reg;
    assign fail_valid = fail_valid_reg;
    assign fail_vec   = fail_vec_reg;

endmodule
